vector_mem_seq: RTL

VECTOR_MEM_SEQ -- requirements
Module: vector_mem_seq

---
 rtl/vector_mem_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vector_mem_seq.sv
// Vector load/store sequencer: moves 16 x 16-bit lanes between memory and a vector register.
// Optional VMEM_STRIDE_EN adds a per-command word stride; default build is stride 1.
module vector_mem_seq #(
  parameter int WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [15:0]           base_addr,
  input  logic [16*WORDS-1:0]   vec_in,
`ifdef VMEM_STRIDE_EN
  input  logic [15:0]           stride,
`endif
  input  logic                  mem_ready,
  input  logic [15:0]           mem_rdata,
  output logic [16*WORDS-1:0]   vec_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [15:0]           mem_wdata
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_STORE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]              idx_q;
  logic [IW-1:0]              rdx_q;
  logic                       rd_pend_q;
  logic [15:0]                base_q;
  logic [WORDS-1:0][15:0]     vec_q;
  logic [WORDS-1:0][15:0]     vout_q;
  logic [15:0]                offs;
  logic                       accept;
  logic                       take;

  assign take   = (state_q == S_IDLE) && start;
  assign accept = (mem_re | mem_we) & mem_ready;

`ifdef VMEM_STRIDE_EN
  logic [15:0] stride_q;

  // Stride is captured with the command so it stays fixed for all lanes.
  always_ff @(posedge clk) begin
    if (rst)
      stride_q <= 16'd1;
    else if (take)
      stride_q <= stride;
  end

  assign offs = stride_q * 16'(idx_q);
`else
  assign offs = 16'(idx_q);
`endif

  // Next-state and request decode.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          state_d = op ? S_STORE : S_LOAD;
      end
      S_LOAD: begin
        mem_re = 1'b1;
        if (mem_ready && idx_q == LAST)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_pend_q && rdx_q == LAST)
          state_d = S_DONE;
      end
      S_STORE: begin
        mem_we = 1'b1;
        if (mem_ready && idx_q == LAST)
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and write data only driven while a request is up.
  assign mem_addr  = (mem_re | mem_we) ? base_q + offs : 16'd0;
  assign mem_wdata = mem_we ? vec_q[idx_q] : 16'd0;
  assign vec_out   = vout_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Command latch: base and store source are frozen for the whole command.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= 16'd0;
      vec_q  <= '0;
    end else if (take) begin
      base_q <= base_addr;
      vec_q  <= vec_in;
    end
  end

  // Issue counter advances only on an accepted request.
  always_ff @(posedge clk) begin
    if (rst)
      idx_q <= '0;
    else if (state_q == S_IDLE)
      idx_q <= '0;
    else if (accept)
      idx_q <= idx_q + 1'b1;
  end

  // Read data is due the cycle after acceptance; reset drops it.
  always_ff @(posedge clk) begin
    if (rst)
      rd_pend_q <= 1'b0;
    else
      rd_pend_q <= mem_re & mem_ready;
  end

  // Returns land in issue order, so a second counter picks the lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdx_q  <= '0;
      vout_q <= '0;
    end else if (state_q == S_IDLE) begin
      rdx_q <= '0;
    end else if (rd_pend_q &&
                 (state_q == S_LOAD || state_q == S_DRAIN)) begin
      vout_q[rdx_q] <= mem_rdata;
      rdx_q         <= rdx_q + 1'b1;
    end
  end

endmodule
